// File: rtl/spi_ram_master_arb.sv
// Round-robin arbiter and SPI frame engine that shares one SPI-attached RAM
// between two requesters: write = {00,addr}{01,data}, read = {10,addr}{11,0} then receive.
module spi_ram_master_arb #(
    parameter int ADDR_SIZE = 8,
    parameter int LEAD_CYC  = 2,
    parameter int GAP_CYC   = 4,
    parameter int TURN_CYC  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req,
    input  logic [1:0]             req_we,
    input  logic [2*ADDR_SIZE-1:0] req_addr,
    input  logic [15:0]            req_wdata,
    output logic [1:0]             gnt,
    output logic [1:0]             done,
    output logic [7:0]             rdata,
    output logic                   busy,
    output logic                   SS_n,
    output logic                   MOSI,
    input  logic                   MISO
);
    localparam int FW = ADDR_SIZE + 2;
    localparam logic [7:0] LEAD_LAST  = 8'(LEAD_CYC - 1);
    localparam logic [7:0] SHIFT_LAST = 8'(FW - 1);
    localparam logic [7:0] TURN_LAST  = 8'(TURN_CYC - 1);
    localparam logic [7:0] RECV_LAST  = 8'd7;
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TURN  = 3'd3,
        ST_RECV  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t                 state_r, state_s;
    logic [7:0]             cnt_r, cnt_s;
    logic                   second_r, second_s;
    logic                   we_r, we_s;
    logic                   own_r, own_s;
    logic                   prio_r, prio_s;
    logic [ADDR_SIZE-1:0]   addr_r, addr_s;
    logic [7:0]             wdata_r, wdata_s;
    logic [FW-1:0]          sh_r, sh_s;
    logic [7:0]             rx_r, rx_s;
    logic                   recv_r, recv_s;
    logic [FW-1:0]          frame_s;
    logic [1:0]             gnt_s, done_s;
    logic [7:0]             rdata_s;
    logic                   busy_s, ss_n_s, mosi_s;

    // Frame to serialise next: address frame first, then data or dummy frame.
    always_comb begin
        if (!second_r) begin
            frame_s = {(we_r ? 2'b00 : 2'b10), addr_r};
        end else if (we_r) begin
            frame_s = {2'b01, ADDR_SIZE'(wdata_r)};
        end else begin
            frame_s = {2'b11, {ADDR_SIZE{1'b0}}};
        end
    end

    // Next-state, arbitration and next values of the registered outputs.
    // Outputs are computed from the current state and appear one cycle later,
    // so the pin timeline trails the state timeline by exactly one clock.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r + 8'd1;
        second_s = second_r;
        we_s     = we_r;
        own_s    = own_r;
        prio_s   = prio_r;
        addr_s   = addr_r;
        wdata_s  = wdata_r;
        sh_s     = sh_r;
        rx_s     = recv_r ? {rx_r[6:0], MISO} : rx_r;
        recv_s   = 1'b0;
        gnt_s    = 2'b00;
        done_s   = 2'b00;
        rdata_s  = rdata;
        ss_n_s   = 1'b1;
        mosi_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s = 8'd0;
                // prio_r names the requester that wins a tie
                if (req[0] && (!req[1] || !prio_r)) begin
                    gnt_s    = 2'b01;
                    own_s    = 1'b0;
                    prio_s   = 1'b1;
                    we_s     = req_we[0];
                    addr_s   = req_addr[0 +: ADDR_SIZE];
                    wdata_s  = req_wdata[7:0];
                    second_s = 1'b0;
                    state_s  = ST_LEAD;
                end else if (req[1]) begin
                    gnt_s    = 2'b10;
                    own_s    = 1'b1;
                    prio_s   = 1'b0;
                    we_s     = req_we[1];
                    addr_s   = req_addr[ADDR_SIZE +: ADDR_SIZE];
                    wdata_s  = req_wdata[15:8];
                    second_s = 1'b0;
                    state_s  = ST_LEAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LEAD: begin
                ss_n_s = 1'b0;
                if (cnt_r == LEAD_LAST) begin
                    cnt_s   = 8'd0;
                    sh_s    = frame_s;
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_LEAD;
                end
            end
            ST_SHIFT: begin
                ss_n_s = 1'b0;
                mosi_s = sh_r[FW-1];
                sh_s   = {sh_r[FW-2:0], 1'b0};
                if (cnt_r == SHIFT_LAST) begin
                    cnt_s   = 8'd0;
                    state_s = (second_r && !we_r) ? ST_TURN : ST_GAP;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_TURN: begin
                ss_n_s = 1'b0;
                if (cnt_r == TURN_LAST) begin
                    cnt_s   = 8'd0;
                    state_s = ST_RECV;
                end else begin
                    state_s = ST_TURN;
                end
            end
            ST_RECV: begin
                ss_n_s = 1'b0;
                recv_s = 1'b1;
                if (cnt_r == RECV_LAST) begin
                    cnt_s   = 8'd0;
                    state_s = ST_GAP;
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_GAP: begin
                if (cnt_r == 8'd0 && second_r) begin
                    done_s[own_r] = 1'b1;
                    // eighth MISO bit is sampled on this same edge
                    rdata_s = we_r ? rdata : {rx_r[6:0], MISO};
                end else begin
                    done_s = 2'b00;
                end
                if (cnt_r == GAP_LAST) begin
                    cnt_s    = 8'd0;
                    state_s  = second_r ? ST_IDLE : ST_LEAD;
                    second_s = 1'b1;
                end else begin
                    state_s = ST_GAP;
                end
            end
            default: begin
                cnt_s   = 8'd0;
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and output registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 8'd0;
            second_r <= 1'b0;
            we_r     <= 1'b0;
            own_r    <= 1'b0;
            prio_r   <= 1'b0;
            addr_r   <= {ADDR_SIZE{1'b0}};
            wdata_r  <= 8'd0;
            sh_r     <= {FW{1'b0}};
            rx_r     <= 8'd0;
            recv_r   <= 1'b0;
            gnt      <= 2'b00;
            done     <= 2'b00;
            rdata    <= 8'd0;
            busy     <= 1'b0;
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            second_r <= second_s;
            we_r     <= we_s;
            own_r    <= own_s;
            prio_r   <= prio_s;
            addr_r   <= addr_s;
            wdata_r  <= wdata_s;
            sh_r     <= sh_s;
            rx_r     <= rx_s;
            recv_r   <= recv_s;
            gnt      <= gnt_s;
            done     <= done_s;
            rdata    <= rdata_s;
            busy     <= busy_s;
            SS_n     <= ss_n_s;
            MOSI     <= mosi_s;
        end
    end
endmodule

// File: tb/tb_spi_ram_master_arb.sv
// Directed bench for spi_ram_master_arb: transaction table with cycle-exact pin
// timeline checks, a bench-side RAM/slave model, plus arbitration and reset sequences.
module tb_spi_ram_master_arb;
    typedef struct {
        bit         sel;
        int         rq;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        int         exp_done;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req0v = 2'b00;
    logic [1:0]  req3v = 2'b00;
    logic [1:0]  req_we_v = 2'b00;
    logic [15:0] req_addr_v = 16'h0000;
    logic [15:0] req_wdata_v = 16'h0000;
    logic        miso = 1'b0;
    logic        sel = 1'b0;

    logic [1:0] gnt0, done0, gnt3, done3, gnt_m, done_m;
    logic [7:0] rdata0, rdata3, rdata_m;
    logic       busy0, ss0, mosi0, busy3, ss3, mosi3, busy_m, ss_m, mosi_m;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int prev_t = 0;
    int prev_done = 0;
    bit prev_valid = 1'b0;
    bit prev_sel = 1'b0;
    logic [7:0] mem [2][256];
    txn_t tbl [8];

    spi_ram_master_arb u_dut (
        .clk(clk), .rst(rst), .req(req0v), .req_we(req_we_v), .req_addr(req_addr_v),
        .req_wdata(req_wdata_v), .gnt(gnt0), .done(done0), .rdata(rdata0), .busy(busy0),
        .SS_n(ss0), .MOSI(mosi0), .MISO(miso)
    );

    spi_ram_master_arb #(.TURN_CYC(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3v), .req_we(req_we_v), .req_addr(req_addr_v),
        .req_wdata(req_wdata_v), .gnt(gnt3), .done(done3), .rdata(rdata3), .busy(busy3),
        .SS_n(ss3), .MOSI(mosi3), .MISO(miso)
    );

    assign gnt_m   = sel ? gnt3   : gnt0;
    assign done_m  = sel ? done3  : done0;
    assign rdata_m = sel ? rdata3 : rdata0;
    assign busy_m  = sel ? busy3  : busy0;
    assign ss_m    = sel ? ss3    : ss0;
    assign mosi_m  = sel ? mosi3  : mosi0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One transaction: request, grant, then a cycle-by-cycle walk of the pins.
    task automatic run_txn(input txn_t t);
        bit         got;
        int         t0, turn, last_lo, ss_err, done_hits, done_at;
        logic [9:0] f1, f2, e1, e2;
        logic [1:0] exp_g, done_val;
        logic [7:0] rbyte, rd;
        bit         exp_lo;
        sel  = t.sel;
        turn = t.sel ? 3 : 2;
        e1 = {(t.we ? 2'b00 : 2'b10), t.addr};
        e2 = t.we ? {2'b01, t.wdata} : {2'b11, 8'h00};
        exp_g = 2'b00;
        exp_g[t.rq] = 1'b1;
        req_we_v[t.rq] = t.we;
        req_addr_v[t.rq*8 +: 8] = t.addr;
        req_wdata_v[t.rq*8 +: 8] = t.wdata;
        if (t.sel) req3v[t.rq] = 1'b1; else req0v[t.rq] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (gnt_m !== 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        req0v = 2'b00;
        req3v = 2'b00;
        chk("gnt_wait", got, 1'b1);
        if (!got) return;
        chk("gnt_onehot", gnt_m, exp_g);
        chk("busy_at_gnt", busy_m, 1'b1);
        if (prev_valid && prev_sel == t.sel) chk("gnt_spacing", cyc - prev_t, prev_done + 4);
        t0 = cyc;
        last_lo = t.we ? 28 : 36 + turn;
        ss_err = 0; done_hits = 0; done_at = 0; done_val = 2'b00;
        f1 = 10'h000; f2 = 10'h000; rbyte = 8'h00; rd = 8'h00;
        for (int k = 1; k <= t.exp_done + 3; k++) begin
            @(negedge clk);
            exp_lo = (k <= 12) || (k >= 17 && k <= last_lo);
            if (ss_m !== ~exp_lo) ss_err++;
            if (gnt_m !== 2'b00) ss_err++;
            if (k >= 3 && k <= 12) f1[12-k] = mosi_m;
            else if (k >= 19 && k <= 28) f2[28-k] = mosi_m;
            else if (mosi_m !== 1'b0) ss_err++;
            if (k == 13) rbyte = mem[t.sel][f1[7:0]];
            if (!t.we && k >= 29 + turn && k <= 36 + turn) miso = rbyte[36+turn-k];
            else miso = 1'b0;
            if (done_m !== 2'b00) begin
                done_hits++;
                done_at = k;
                done_val = done_m;
            end
            if (k == t.exp_done) rd = rdata_m;
        end
        chk("frame1", f1, e1);
        chk("frame2", f2, e2);
        chk("ss_mosi_timeline_errs", ss_err, 0);
        chk("done_count", done_hits, 1);
        chk("done_cycle", done_at, t.exp_done);
        chk("done_owner", done_val, exp_g);
        if (t.we) mem[t.sel][f1[7:0]] = f2[7:0];
        else chk("rdata", rd, t.exp_rdata);
        prev_t = t0;
        prev_done = t.exp_done;
        prev_sel = t.sel;
        prev_valid = 1'b1;
    endtask

    initial begin
        int   ng, rise_cyc;
        bit   seen, got;
        logic prev_ss;
        logic [1:0] exp_g;
        for (int a = 0; a < 256; a++) begin
            mem[0][a] = 8'h00;
            mem[1][a] = 8'h00;
        end
        tbl[0] = '{1'b0, 0, 1'b1, 8'hFF, 8'hAB, 8'h00, 29};
        tbl[1] = '{1'b0, 1, 1'b0, 8'hFF, 8'h00, 8'hAB, 39};
        tbl[2] = '{1'b0, 1, 1'b1, 8'h00, 8'h44, 8'h00, 29};
        tbl[3] = '{1'b0, 1, 1'b1, 8'h01, 8'h55, 8'h00, 29};
        tbl[4] = '{1'b0, 1, 1'b1, 8'h02, 8'h66, 8'h00, 29};
        tbl[5] = '{1'b0, 0, 1'b0, 8'h01, 8'h00, 8'h55, 39};
        tbl[6] = '{1'b1, 0, 1'b1, 8'h00, 8'h3C, 8'h00, 29};
        tbl[7] = '{1'b1, 1, 1'b0, 8'h00, 8'h00, 8'h3C, 40};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ss_n", ss0, 1'b1);
        chk("rst_mosi", mosi0, 1'b0);
        chk("rst_gnt", gnt0, 2'b00);
        chk("rst_done", done0, 2'b00);
        chk("rst_rdata", rdata0, 8'h00);
        chk("rst_busy", busy0, 1'b0);
        rst = 1'b0;

        // both requesters continuously asking: grants alternate 0,1,0,1
        req_we_v = 2'b11; req_addr_v = 16'h2010; req_wdata_v = 16'h2211;
        req0v = 2'b11;
        ng = 0; prev_ss = 1'b1; rise_cyc = -100;
        for (int i = 0; i < 400 && ng < 4; i++) begin
            @(negedge clk);
            if (ss0 === 1'b1 && prev_ss === 1'b0) rise_cyc = cyc;
            prev_ss = ss0;
            if (gnt0 !== 2'b00) begin
                exp_g = (ng % 2 == 0) ? 2'b01 : 2'b10;
                chk($sformatf("arb_order_%0d", ng), gnt0, exp_g);
                if (ng > 0) chk($sformatf("arb_gap_%0d", ng), cyc - rise_cyc, 4);
                ng++;
                if (ng == 4) req0v = 2'b00;
            end
        end
        req0v = 2'b00;
        chk("arb_grants", ng, 4);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy0 === 1'b0) break;
        end
        chk("arb_idle", busy0, 1'b0);

        // reset during the fifth address bit of a read
        req_we_v[1] = 1'b0; req_addr_v[15:8] = 8'h5A; req0v = 2'b10;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt0 !== 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        req0v = 2'b00;
        chk("rst5_gnt", gnt0, 2'b10);
        repeat (7) @(negedge clk);
        chk("rst5_in_shift", ss0, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst5_ss_n", ss0, 1'b1);
        chk("rst5_mosi", mosi0, 1'b0);
        chk("rst5_busy", busy0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done0 !== 2'b00 || busy0 !== 1'b0 || ss0 !== 1'b1) seen = 1'b1;
        end
        chk("rst5_abandoned", seen, 1'b0);
        prev_valid = 1'b0;
        run_txn('{1'b0, 0, 1'b1, 8'h20, 8'h77, 8'h00, 29});

        // table-driven transactions
        for (int n = 0; n < 8; n++) run_txn(tbl[n]);

        chk("mem_ff", mem[0][8'hFF], 8'hAB);
        chk("mem_00", mem[0][8'h00], 8'h44);
        chk("mem_01", mem[0][8'h01], 8'h55);
        chk("mem_02", mem[0][8'h02], 8'h66);
        chk("mem_20", mem[0][8'h20], 8'h77);
        chk("rdata_hold", rdata3, 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_ram_master_arb.md
Name: spi_ram_master_arb

Overview:
- Host-side controller that shares one SPI-attached single-port RAM (SPI slave plus RAM wrapper) between two requesters.
- Arbitrates round-robin between the requesters and turns each accepted byte write or read into the slave's 10-bit framed command sequence on SS_n/MOSI.
- For reads, collects the returned byte from MISO.
- Runs on the same clk as the slave; one MOSI bit per clk.

Parameters:
- ADDR_SIZE, 8, RAM address width; one frame payload = ADDR_SIZE bits.
- LEAD_CYC, 2, cycles SS_n is low with MOSI=0 before the first command bit.
- GAP_CYC, 4, cycles SS_n is held high between frames and after the final frame.
- TURN_CYC, 2, cycles between the last bit of a read-data frame and the first MISO sample.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  2  request per requester; held high until gnt.
- req_we  in  2  1=write, 0=read, per requester.
- req_addr  in  2*ADDR_SIZE  requester i address at [i*ADDR_SIZE +: ADDR_SIZE].
- req_wdata  in  16  requester i write byte at [i*8 +: 8].
- gnt  out  2  one-cycle pulse, one-hot; the request is latched on this cycle.
- done  out  2  one-cycle pulse to the owning requester when the transaction completes.
- rdata  out  8  read byte; valid in the done cycle of a read, holds until the next read done.
- busy  out  1  high from the gnt cycle until the state machine is back in IDLE.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial command/data to the slave, MSB first.
- MISO  in  1  serial read data from the slave.

Behaviour:
- Reset (asynchronous, any state):
  - SS_n=1, MOSI=0, gnt=0, done=0, rdata=0, busy=0.
  - State=IDLE, round-robin pointer favours requester 0.
  - A transaction in flight is abandoned with no done pulse.
- All outputs are registered.
- Frame format: 2-bit command then ADDR_SIZE payload bits, MSB first.
  - 00 = write address.
  - 01 = write data.
  - 10 = read address.
  - 11 = read data; payload is all zeros (dummy).
- Write transaction = frame 00+addr, then frame 01+wdata.
- Read transaction = frame 10+addr, then frame 11+dummy followed by TURN_CYC wait and 8 receive cycles, all with SS_n kept low.
- States: IDLE -> LEAD -> SHIFT -> (TURN -> RECV, read-data frame only) -> GAP -> LEAD for the second frame, or GAP -> IDLE after the second frame.
- IDLE:
  - Evaluates req only here.
  - Single requester: grant it.
  - Both requesting: grant the one not granted last; after reset requester 0 wins a tie.
  - Grant cycle T: gnt pulses; we/addr/wdata latched; busy=1; pointer updated.
  - No request: stay in IDLE, outputs idle.
- LEAD: SS_n=0, MOSI=0 for LEAD_CYC cycles.
- SHIFT: 10 cycles; frame bit k (k=9 down to 0) is driven on MOSI for exactly one cycle.
- TURN: SS_n=0, MOSI=0 for TURN_CYC cycles.
- RECV:
  - 8 cycles; MISO sampled at the end of each cycle, MSB first, into a shift register.
  - rdata is updated only at done.
- GAP: SS_n=1, MOSI=0 for GAP_CYC cycles.
  - done pulses in the first GAP cycle after the second frame.
  - For reads, rdata is valid in that same cycle.
- Timing with default parameters (gnt at T):
  - Write: SS_n low T+1..T+12 and T+17..T+28; done at T+29; next gnt no earlier than T+33.
  - Read: SS_n low T+1..T+12 and T+17..T+38; MISO sampled T+31..T+38; done at T+39; next gnt no earlier than T+43.
- Requests raised while busy wait; a req dropped before gnt is simply not served.
- The same requester may be re-granted back-to-back if the other is not requesting.

Test Plan:
1. Req0 writes addr 0xFF, data 0xAB -> gnt[0] at T; MOSI 00_11111111 then 01_10101011 at the timing above; done[0] at T+29; bench RAM model mem[0xFF]=0xAB.
2. Req1 reads addr 0xFF, slave model returns 0xAB -> frames 10_11111111 and 11_00000000; done[1] at T+39; rdata=0xAB.
3. Both request in the same IDLE cycle after reset, back-to-back -> order of grants is 0,1,0,1; each gnt one-hot; second gnt exactly GAP_CYC cycles after the prior SS_n rise.
4. Req1 alone issues three consecutive writes (addr 0x00 with 0x44, 0x01 with 0x55, 0x02 with 0x66) -> three grants to requester 1; RAM holds all three values.
5. rst pulsed during the 5th SHIFT bit of a read -> SS_n=1 and MOSI=0 immediately (asynchronous); no done; next req0 write completes normally.
6. Read of addr 0x00 holding 0x3C with TURN_CYC=3 -> first MISO sample one cycle later than default; rdata=0x3C.
